// File: rtl/arith_rs.sv
// arith_rs: reservation station ahead of the arithmetic unit.
// Collapsing queue (entry 0 oldest) that snoops the CDB for operands and
// issues the oldest entry whose two sources are ready.
module arith_rs #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             flush_i,
    input  logic             disp_valid_i,
    output logic             disp_ready_o,
    input  logic [31:0]      disp_pc_i,
    input  logic [31:0]      disp_inst_i,
    input  logic [TAG_W-1:0] disp_dest_tag_i,
    input  logic             disp_rs1_rdy_i,
    input  logic [TAG_W-1:0] disp_rs1_tag_i,
    input  logic [31:0]      disp_rs1_val_i,
    input  logic             disp_rs2_rdy_i,
    input  logic [TAG_W-1:0] disp_rs2_tag_i,
    input  logic [31:0]      disp_rs2_val_i,
    input  logic             cdb_valid_i,
    input  logic [TAG_W-1:0] cdb_tag_i,
    input  logic [31:0]      cdb_value_i,
    output logic             issue_valid_o,
    input  logic             issue_ready_i,
    output logic [31:0]      issue_pc_o,
    output logic [31:0]      issue_inst_o,
    output logic [31:0]      issue_rs1_value_o,
    output logic [31:0]      issue_rs2_value_o,
    output logic [TAG_W-1:0] issue_dest_tag_o,
    output logic [3:0]       count_o
);

    typedef struct packed {
        logic             valid;
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic [TAG_W-1:0] dest;
        logic             rs1_rdy;
        logic [TAG_W-1:0] rs1_tag;
        logic [31:0]      rs1_val;
        logic             rs2_rdy;
        logic [TAG_W-1:0] rs2_tag;
        logic [31:0]      rs2_val;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    entry_t           woke  [DEPTH+1];
    entry_t           new_ent;
    entry_t           sel_ent;
    logic             sel_found;
    logic [DEPTH-1:0] shift_mask;
    logic             issue_fire;
    logic             disp_fire;
    logic [3:0]       wr_idx;
    logic [3:0]       count_q, count_d;

    // CDB wakeup view of every entry; the extra top slot is an empty entry
    // that shifts in when the queue collapses.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            woke[i] = ent_q[i];
            if (cdb_valid_i && ent_q[i].valid) begin
                if (!ent_q[i].rs1_rdy && ent_q[i].rs1_tag == cdb_tag_i) begin
                    woke[i].rs1_rdy = 1'b1;
                    woke[i].rs1_val = cdb_value_i;
                end
                if (!ent_q[i].rs2_rdy && ent_q[i].rs2_tag == cdb_tag_i) begin
                    woke[i].rs2_rdy = 1'b1;
                    woke[i].rs2_val = cdb_value_i;
                end
            end
        end
        woke[DEPTH] = '0;
    end

    // Oldest-ready select on registered rdy bits; shift_mask marks the
    // selected entry and everything younger (those move down on issue).
    always_comb begin
        sel_found  = 1'b0;
        sel_ent    = '0;
        shift_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!sel_found && ent_q[i].valid && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
                sel_found = 1'b1;
                sel_ent   = ent_q[i];
            end
            shift_mask[i] = sel_found;
        end
    end

    // Issue outputs come straight from the selected entry (zero when none).
    always_comb begin
        issue_valid_o     = sel_found;
        issue_pc_o        = sel_ent.pc;
        issue_inst_o      = sel_ent.inst;
        issue_rs1_value_o = sel_ent.rs1_val;
        issue_rs2_value_o = sel_ent.rs2_val;
        issue_dest_tag_o  = sel_ent.dest;
        count_o           = count_q;
    end

    // Incoming entry, with same-cycle CDB capture for sources not yet ready.
    always_comb begin
        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.pc      = disp_pc_i;
        new_ent.inst    = disp_inst_i;
        new_ent.dest    = disp_dest_tag_i;
        new_ent.rs1_rdy = disp_rs1_rdy_i;
        new_ent.rs1_tag = disp_rs1_tag_i;
        new_ent.rs1_val = disp_rs1_val_i;
        new_ent.rs2_rdy = disp_rs2_rdy_i;
        new_ent.rs2_tag = disp_rs2_tag_i;
        new_ent.rs2_val = disp_rs2_val_i;
        if (cdb_valid_i && !disp_rs1_rdy_i && disp_rs1_tag_i == cdb_tag_i) begin
            new_ent.rs1_rdy = 1'b1;
            new_ent.rs1_val = cdb_value_i;
        end
        if (cdb_valid_i && !disp_rs2_rdy_i && disp_rs2_tag_i == cdb_tag_i) begin
            new_ent.rs2_rdy = 1'b1;
            new_ent.rs2_val = cdb_value_i;
        end
    end

    // Next state: collapse on issue, append dispatch at the tail, flush wins.
    // Readiness uses count before any same-cycle issue, so a slot freed by
    // issue is not reused in the same cycle.
    always_comb begin
        disp_ready_o = (32'(count_q) < DEPTH) && !flush_i;
        issue_fire   = sel_found && issue_ready_i;
        disp_fire    = disp_valid_i && disp_ready_o;
        wr_idx       = count_q - {3'b000, issue_fire};
        count_d      = count_q + {3'b000, disp_fire} - {3'b000, issue_fire};
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_d[i] = (issue_fire && shift_mask[i]) ? woke[i+1] : woke[i];
            if (disp_fire && 4'(i) == wr_idx) begin
                ent_d[i] = new_ent;
            end
        end
        if (flush_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_d[i] = '0;
            end
            count_d = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_arith_rs.sv
// tb_arith_rs: directed and randomized checks of arith_rs against a
// queue-based reference model of the reservation station.
module tb_arith_rs;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [5:0]  dest;
        logic        r1rdy;
        logic [5:0]  r1tag;
        logic [31:0] r1val;
        logic        r2rdy;
        logic [5:0]  r2tag;
        logic [31:0] r2val;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        disp_valid_i = 1'b0;
    logic        disp_ready_o;
    logic [31:0] disp_pc_i = '0, disp_inst_i = '0;
    logic [5:0]  disp_dest_tag_i = '0;
    logic        disp_rs1_rdy_i = 1'b0, disp_rs2_rdy_i = 1'b0;
    logic [5:0]  disp_rs1_tag_i = '0, disp_rs2_tag_i = '0;
    logic [31:0] disp_rs1_val_i = '0, disp_rs2_val_i = '0;
    logic        cdb_valid_i = 1'b0;
    logic [5:0]  cdb_tag_i = '0;
    logic [31:0] cdb_value_i = '0;
    logic        issue_valid_o;
    logic        issue_ready_i = 1'b0;
    logic [31:0] issue_pc_o, issue_inst_o, issue_rs1_value_o, issue_rs2_value_o;
    logic [5:0]  issue_dest_tag_o;
    logic [3:0]  count_o;

    int checks = 0;
    int failures = 0;
    ent_t q[$];

    arith_rs #(.DEPTH(DEPTH), .TAG_W(6)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .flush_i(flush_i),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_pc_i(disp_pc_i), .disp_inst_i(disp_inst_i), .disp_dest_tag_i(disp_dest_tag_i),
        .disp_rs1_rdy_i(disp_rs1_rdy_i), .disp_rs1_tag_i(disp_rs1_tag_i), .disp_rs1_val_i(disp_rs1_val_i),
        .disp_rs2_rdy_i(disp_rs2_rdy_i), .disp_rs2_tag_i(disp_rs2_tag_i), .disp_rs2_val_i(disp_rs2_val_i),
        .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_value_i(cdb_value_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .issue_pc_o(issue_pc_o), .issue_inst_o(issue_inst_o),
        .issue_rs1_value_o(issue_rs1_value_o), .issue_rs2_value_o(issue_rs2_value_o),
        .issue_dest_tag_o(issue_dest_tag_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc, input logic r1rdy, input logic [5:0] r1tag,
                                input logic [31:0] r1val, input logic r2rdy, input logic [5:0] r2tag,
                                input logic [31:0] r2val);
        ent_t e;
        e.pc = pc; e.inst = pc ^ 32'hA5A5_0000; e.dest = pc[7:2];
        e.r1rdy = r1rdy; e.r1tag = r1tag; e.r1val = r1val;
        e.r2rdy = r2rdy; e.r2tag = r2tag; e.r2val = r2val;
        return e;
    endfunction

    // One cycle: drive just after negedge, check outputs, advance model at posedge.
    task automatic step(input logic fl, input logic dv, input ent_t d, input logic cv,
                        input logic [5:0] ct, input logic [31:0] cval, input logic ir);
        logic exp_rdy;
        int   sel;
        ent_t n;
        flush_i = fl; disp_valid_i = dv;
        disp_pc_i = d.pc; disp_inst_i = d.inst; disp_dest_tag_i = d.dest;
        disp_rs1_rdy_i = d.r1rdy; disp_rs1_tag_i = d.r1tag; disp_rs1_val_i = d.r1val;
        disp_rs2_rdy_i = d.r2rdy; disp_rs2_tag_i = d.r2tag; disp_rs2_val_i = d.r2val;
        cdb_valid_i = cv; cdb_tag_i = ct; cdb_value_i = cval; issue_ready_i = ir;
        #1;
        exp_rdy = (q.size() < DEPTH) && !fl;
        sel = -1;
        foreach (q[k]) if (sel < 0 && q[k].r1rdy && q[k].r2rdy) sel = k;
        check_eq("disp_ready", 32'(disp_ready_o), 32'(exp_rdy));
        check_eq("issue_valid", 32'(issue_valid_o), 32'(sel >= 0));
        check_eq("count", 32'(count_o), 32'(q.size()));
        if (sel >= 0) begin
            check_eq("issue_pc", issue_pc_o, q[sel].pc);
            check_eq("issue_inst", issue_inst_o, q[sel].inst);
            check_eq("issue_rs1", issue_rs1_value_o, q[sel].r1val);
            check_eq("issue_rs2", issue_rs2_value_o, q[sel].r2val);
            check_eq("issue_dest", 32'(issue_dest_tag_o), 32'(q[sel].dest));
        end
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            foreach (q[k]) begin
                if (cv && !q[k].r1rdy && q[k].r1tag == ct) begin q[k].r1rdy = 1'b1; q[k].r1val = cval; end
                if (cv && !q[k].r2rdy && q[k].r2tag == ct) begin q[k].r2rdy = 1'b1; q[k].r2val = cval; end
            end
            if (sel >= 0 && ir) q.delete(sel);
            if (dv && exp_rdy) begin
                n = d;
                if (cv && !n.r1rdy && n.r1tag == ct) begin n.r1rdy = 1'b1; n.r1val = cval; end
                if (cv && !n.r2rdy && n.r2tag == ct) begin n.r2rdy = 1'b1; n.r2val = cval; end
                q.push_back(n);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ir);
        step(1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0), 1'b0, 6'd0, 32'd0, ir);
    endtask

    task automatic disp(input ent_t d, input logic ir);
        step(1'b0, 1'b1, d, 1'b0, 6'd0, 32'd0, ir);
    endtask

    task automatic bcast(input logic [5:0] t, input logic [31:0] v, input logic ir);
        step(1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0), 1'b1, t, v, ir);
    endtask

    initial begin
        ent_t r;
        #2;
        check_eq("rst_count", 32'(count_o), 32'd0);
        check_eq("rst_issue_valid", 32'(issue_valid_o), 32'd0);
        check_eq("rst_disp_ready", 32'(disp_ready_o), 32'd1);
        check_eq("rst_issue_pc", issue_pc_o, 32'd0);
        check_eq("rst_issue_rs1", issue_rs1_value_o, 32'd0);
        check_eq("rst_issue_dest", 32'(issue_dest_tag_o), 32'd0);
        @(negedge clk);
        reset_ni = 1'b1;

        // Basic issue with both sources ready.
        disp(mk(32'h100, 1, 0, 5, 1, 0, 7), 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Younger ready entry bypasses an older waiting one; CDB wakes the older.
        disp(mk(32'h200, 0, 3, 0, 1, 0, 2), 1'b1);
        disp(mk(32'h204, 1, 0, 1, 1, 0, 1), 1'b1);
        idle(1'b1);
        bcast(6'd3, 32'h55, 1'b1);
        idle(1'b1);
        idle(1'b0);

        // Fill with waiting entries, wake in reverse order.
        for (int i = 0; i < 4; i++) disp(mk(32'h300 + 32'(4 * i), 0, 6'(10 + i), 0, 1, 0, 32'(i)), 1'b1);
        disp(mk(32'h3F0, 1, 0, 0, 1, 0, 0), 1'b1);
        for (int i = 3; i >= 0; i--) bcast(6'(10 + i), 32'h1000 + 32'(i), 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Dispatch captures a same-cycle CDB broadcast of its rs2 tag.
        step(1'b0, 1'b1, mk(32'h400, 1, 0, 3, 0, 9, 0), 1'b1, 6'd9, 32'hABCD, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Simultaneous dispatch and issue at count 2.
        disp(mk(32'h500, 1, 0, 1, 1, 0, 1), 1'b0);
        disp(mk(32'h504, 1, 0, 2, 1, 0, 2), 1'b0);
        disp(mk(32'h508, 1, 0, 3, 1, 0, 3), 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Flush with three entries held.
        for (int i = 0; i < 3; i++) disp(mk(32'h600 + 32'(4 * i), 1, 0, 9, 1, 0, 9), 1'b0);
        step(1'b1, 1'b1, mk(32'h6F0, 1, 0, 0, 1, 0, 0), 1'b0, 6'd0, 32'd0, 1'b1);
        idle(1'b0);

        // Asynchronous reset mid-stream.
        disp(mk(32'h700, 1, 0, 1, 1, 0, 1), 1'b0);
        disp(mk(32'h704, 0, 5, 1, 1, 0, 1), 1'b0);
        #2;
        reset_ni = 1'b0;
        #1;
        check_eq("midrst_count", 32'(count_o), 32'd0);
        check_eq("midrst_issue_valid", 32'(issue_valid_o), 32'd0);
        check_eq("midrst_disp_ready", 32'(disp_ready_o), 32'd1);
        q.delete();
        @(negedge clk);
        reset_ni = 1'b1;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            r.pc = $urandom; r.inst = $urandom; r.dest = 6'($urandom);
            r.r1rdy = 1'($urandom); r.r1tag = 6'($urandom_range(0, 7)); r.r1val = $urandom;
            r.r2rdy = 1'($urandom); r.r2tag = 6'($urandom_range(0, 7)); r.r2val = $urandom;
            step(($urandom % 40) == 0, ($urandom % 3) != 0, r, 1'($urandom),
                 6'($urandom_range(0, 7)), $urandom, ($urandom % 4) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
